// File: rtl/trigger_wheel_gen_if.sv
// Trigger-wheel generator control and waveform bundle.
// master drives control/config, slave is the wheel generator.
interface trigger_wheel_gen_if #(
   parameter int TEETH   = 60,
   parameter int PER_W   = 16,
   parameter int CAM_CH  = 2,
   parameter int TW      = $clog2(TEETH)
);
   logic                 load;
   logic                 en;
   logic [PER_W-1:0]     per_init;
   logic [PER_W-1:0]     per_target;
   logic [PER_W-1:0]     per_step;
   logic [CAM_CH*TW-1:0] cam_start;
   logic [CAM_CH*TW-1:0] cam_stop;
   logic [CAM_CH-1:0]    cam_sel;
   logic                 crank_out;
   logic [CAM_CH-1:0]    cam_out;
   logic [TW-1:0]        tooth_idx;
   logic                 phase;
   logic [PER_W-1:0]     per_cur;
   logic                 rev_stb;
   logic                 busy;

   modport master (
      output load, en, per_init, per_target, per_step,
      output cam_start, cam_stop, cam_sel,
      input  crank_out, cam_out, tooth_idx, phase,
      input  per_cur, rev_stb, busy
   );

   modport slave (
      input  load, en, per_init, per_target, per_step,
      input  cam_start, cam_stop, cam_sel,
      output crank_out, cam_out, tooth_idx, phase,
      output per_cur, rev_stb, busy
   );
endinterface

// File: rtl/trigger_wheel_gen.sv
// Crank/cam trigger-wheel pattern generator with
// linear tooth-period ramp toward a target speed.
module trigger_wheel_gen #(
   parameter int TEETH   = 60,
   parameter int MISSING = 2,
   parameter int PER_W   = 16,
   parameter int CAM_CH  = 2,
   parameter int TW      = $clog2(TEETH)
) (
   input logic           clk,
   input logic           rst,
   trigger_wheel_gen_if.slave tw
);
   localparam int N  = TEETH - MISSING;
   localparam int CW = PER_W + $clog2(MISSING + 2);

   logic [CW-1:0]     cnt;
   logic [TW-1:0]     idx_q;
   logic              ph_q;
   logic [PER_W-1:0]  per_q;
   logic              crank_q;
   logic [CAM_CH-1:0] cam_q;
   logic              rev_q;
   logic              busy_q;

   logic [CW-1:0]     len;
   logic [CW-1:0]     half;
   logic [CW-1:0]     cnt_inc;
   logic              last;
   logic              wrap;
   logic [TW-1:0]     idx_nx;
   logic              ph_nx;
   logic [PER_W-1:0]  per_nx;
   logic [PER_W-1:0]  init_c;
   logic [PER_W-1:0]  tgt_c;
   logic [PER_W:0]    pc;
   logic [PER_W:0]    tg;
   logic [PER_W:0]    st;
   logic [CAM_CH-1:0] cam_nx;
   logic [CAM_CH-1:0] cam_ld;

   function automatic logic [PER_W-1:0] clamp2(
      input logic [PER_W-1:0] v
   );
      return (v < PER_W'(2)) ? PER_W'(2) : v;
   endfunction

   function automatic logic [CAM_CH-1:0] cam_eval(
      input logic [TW-1:0]        idx,
      input logic                 ph,
      input logic [CAM_CH*TW-1:0] s_all,
      input logic [CAM_CH*TW-1:0] e_all,
      input logic [CAM_CH-1:0]    sel
   );
      logic [CAM_CH-1:0] r;
      logic [TW-1:0]     s;
      logic [TW-1:0]     e;
      logic              hit;
      r = '0;
      for (int c = 0; c < CAM_CH; c++) begin
         s   = s_all[c*TW +: TW];
         e   = e_all[c*TW +: TW];
         hit = 1'b0;
         if (s < e)
            hit = (idx >= s) && (idx < e);
         else if (s > e)
            hit = (idx >= s) || (idx < e);
         r[c] = hit && (ph == sel[c]);
      end
      return r;
   endfunction

   // Tooth length, boundary detect and next-tooth values.
   always_comb begin
      wrap    = (idx_q == TW'(N - 1));
      len     = wrap ? CW'(per_q) * CW'(MISSING + 1)
                     : CW'(per_q);
      half    = len >> 1;
      cnt_inc = cnt + CW'(1);
      last    = (cnt == len - CW'(1));
      idx_nx  = wrap ? '0 : idx_q + TW'(1);
      ph_nx   = ph_q ^ wrap;
      init_c  = clamp2(tw.per_init);
      tgt_c   = clamp2(tw.per_target);
      cam_nx  = cam_eval(idx_nx, ph_nx, tw.cam_start,
                         tw.cam_stop, tw.cam_sel);
      cam_ld  = cam_eval('0, 1'b0, tw.cam_start,
                         tw.cam_stop, tw.cam_sel);
   end

   // Period ramp toward target, never overshooting.
   always_comb begin
      pc     = {1'b0, per_q};
      tg     = {1'b0, tgt_c};
      st     = {1'b0, tw.per_step};
      per_nx = per_q;
      if (pc > tg) begin
         if (st >= pc - tg) per_nx = tgt_c;
         else               per_nx = per_q - tw.per_step;
      end else if (pc < tg) begin
         if (st >= tg - pc) per_nx = tgt_c;
         else               per_nx = per_q + tw.per_step;
      end
   end

   // Wheel state: load restarts, en advances, else hold.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt     <= '0;
         idx_q   <= '0;
         ph_q    <= 1'b0;
         per_q   <= '0;
         crank_q <= 1'b0;
         cam_q   <= '0;
         rev_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else if (tw.load) begin
         cnt     <= '0;
         idx_q   <= '0;
         ph_q    <= 1'b0;
         per_q   <= init_c;
         crank_q <= 1'b0;
         cam_q   <= cam_ld;
         rev_q   <= 1'b1;
         busy_q  <= 1'b1;
      end else if (busy_q && tw.en) begin
         if (last) begin
            cnt     <= '0;
            idx_q   <= idx_nx;
            ph_q    <= ph_nx;
            per_q   <= per_nx;
            crank_q <= 1'b0;
            cam_q   <= cam_nx;
            rev_q   <= wrap;
         end else begin
            cnt     <= cnt_inc;
            crank_q <= (cnt_inc >= half);
            rev_q   <= 1'b0;
         end
      end
   end

   assign tw.crank_out = crank_q;
   assign tw.cam_out   = cam_q;
   assign tw.tooth_idx = idx_q;
   assign tw.phase     = ph_q;
   assign tw.per_cur   = per_q;
   assign tw.rev_stb   = rev_q;
   assign tw.busy      = busy_q;
endmodule

// File: tb/tb_trigger_wheel_gen.sv
// Self-checking bench: vector table, corner sequences
// and randomized runs against a tooth-schedule model.
module tb_trigger_wheel_gen;
   localparam int TEETH   = 60;
   localparam int MISSING = 2;
   localparam int PER_W   = 16;
   localparam int CAM_CH  = 2;
   localparam int TW      = 6;
   localparam int N       = TEETH - MISSING;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   trigger_wheel_gen_if #(
      .TEETH(TEETH), .PER_W(PER_W),
      .CAM_CH(CAM_CH), .TW(TW)
   ) tw ();

   trigger_wheel_gen #(
      .TEETH(TEETH), .MISSING(MISSING), .PER_W(PER_W),
      .CAM_CH(CAM_CH), .TW(TW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .tw(tw)
   );

   int n_chk  = 0;
   int n_pass = 0;
   bit last_ok;

   int cs [2];
   int ce [2];
   bit sel [2];

   typedef struct {
      int idx;
      bit ph;
      int per;
      int len;
      int start;
      logic [1:0] cam;
   } tooth_t;

   tooth_t sched [$];
   int kp;

   typedef struct {
      int pi, pt, ps, cyc;
      int idx, per;
      bit crank, ph, rev;
   } vec_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm,
                      input logic [63:0] got,
                      input logic [63:0] want);
      n_chk++;
      last_ok = (got === want);
      if (last_ok) n_pass++;
      else $display("FAIL %s got %0h want %0h", nm, got, want);
   endtask

   function automatic logic [63:0] pack(
      bit cr, logic [1:0] cam, int idx, bit ph,
      int per, bit rev, bit busy);
      return {36'b0, cr, cam, 6'(idx), ph,
              16'(per), rev, busy};
   endfunction

   function automatic logic [63:0] outv();
      return {36'b0, tw.crank_out, tw.cam_out,
              tw.tooth_idx, tw.phase, tw.per_cur,
              tw.rev_stb, tw.busy};
   endfunction

   // Marks every tooth of a channel window by walking
   // from start to stop around the wheel.
   function automatic logic [1:0] cam_model(int idx, bit ph);
      logic [1:0] r;
      bit on [0:N-1];
      int i;
      r = '0;
      for (int c = 0; c < 2; c++) begin
         for (int k = 0; k < N; k++) on[k] = 1'b0;
         i = cs[c];
         while (i != ce[c]) begin
            on[i] = 1'b1;
            i = (i + 1) % N;
         end
         r[c] = on[idx] && (ph == sel[c]);
      end
      return r;
   endfunction

   task automatic build(input int pi, input int pt,
                        input int ps, input int hz);
      int p, tg, idx, st;
      bit ph;
      tooth_t e;
      sched.delete();
      p   = (pi < 2) ? 2 : pi;
      tg  = (pt < 2) ? 2 : pt;
      idx = 0;
      ph  = 1'b0;
      st  = 0;
      while (st <= hz) begin
         e.idx   = idx;
         e.ph    = ph;
         e.per   = p;
         e.len   = (idx == N - 1) ? (MISSING + 1) * p : p;
         e.start = st;
         e.cam   = cam_model(idx, ph);
         sched.push_back(e);
         st += e.len;
         idx++;
         if (idx == N) begin
            idx = 0;
            ph  = ~ph;
         end
         if (p > tg) p = (p - ps > tg) ? p - ps : tg;
         else if (p < tg) p = (p + ps < tg) ? p + ps : tg;
      end
   endtask

   task automatic model_at(input int t,
                           output logic [63:0] v);
      tooth_t s;
      while (kp + 1 < sched.size() &&
             t >= sched[kp].start + sched[kp].len)
         kp++;
      s = sched[kp];
      v = pack((t - s.start) >= s.len / 2, s.cam, s.idx,
               s.ph, s.per,
               (t == s.start) && (s.idx == 0), 1'b1);
   endtask

   task automatic apply_cfg(input int pi, input int pt,
                            input int ps);
      tw.cam_start  = {6'(cs[1]), 6'(cs[0])};
      tw.cam_stop   = {6'(ce[1]), 6'(ce[0])};
      tw.cam_sel    = {sel[1], sel[0]};
      tw.per_init   = 16'(pi);
      tw.per_target = 16'(pt);
      tw.per_step   = 16'(ps);
   endtask

   task automatic do_load(input bit en_at_load);
      tw.en   = en_at_load;
      tw.load = 1'b1;
      tick();
      tw.load = 1'b0;
   endtask

   task automatic run_check(input string nm, input int pi,
                            input int pt, input int ps,
                            input int cycles, input int en_pct,
                            input bit en_at_load);
      logic [63:0] v;
      int t;
      apply_cfg(pi, pt, ps);
      build(pi, pt, ps, cycles + 2);
      kp = 0;
      t  = 0;
      do_load(en_at_load);
      model_at(t, v);
      chk({nm, "_load"}, outv(), v);
      for (int i = 0; i < cycles; i++) begin
         tw.en = ($urandom_range(99) < en_pct);
         tick();
         if (tw.en) t++;
         model_at(t, v);
         chk($sformatf("%s_c%0d", nm, i), outv(), v);
         if (!last_ok) break;
      end
   endtask

   task automatic wait_idx(input int target, input int budget,
                           input string nm);
      int n;
      n = 0;
      while (tw.tooth_idx != TW'(target) && n < budget) begin
         tick();
         n++;
      end
      chk({"wait_", nm}, 64'(tw.tooth_idx), 64'(target));
   endtask

   vec_t vt [19];

   initial begin
      vt[0]  = '{64, 64, 0, 0,     0, 64, 0, 0, 1};
      vt[1]  = '{64, 64, 0, 31,    0, 64, 0, 0, 0};
      vt[2]  = '{64, 64, 0, 32,    0, 64, 1, 0, 0};
      vt[3]  = '{64, 64, 0, 64,    1, 64, 0, 0, 0};
      vt[4]  = '{64, 64, 0, 3647, 56, 64, 1, 0, 0};
      vt[5]  = '{64, 64, 0, 3648, 57, 64, 0, 0, 0};
      vt[6]  = '{64, 64, 0, 3743, 57, 64, 0, 0, 0};
      vt[7]  = '{64, 64, 0, 3744, 57, 64, 1, 0, 0};
      vt[8]  = '{64, 64, 0, 3840,  0, 64, 0, 1, 1};
      vt[9]  = '{128, 100, 1, 128,  1, 127, 0, 0, 0};
      vt[10] = '{128, 100, 1, 3205, 27, 101, 1, 0, 0};
      vt[11] = '{128, 100, 1, 3206, 28, 100, 0, 0, 0};
      vt[12] = '{1, 0, 0, 1,    0, 2, 1, 0, 0};
      vt[13] = '{1, 0, 0, 2,    1, 2, 0, 0, 0};
      vt[14] = '{1, 0, 0, 116, 57, 2, 0, 0, 0};
      vt[15] = '{1, 0, 0, 117, 57, 2, 1, 0, 0};
      vt[16] = '{1, 0, 0, 120,  0, 2, 0, 1, 1};
      vt[17] = '{10, 0, 3, 20,  2, 4, 1, 0, 0};
      vt[18] = '{2, 9, 4, 17,   3, 9, 0, 0, 0};

      rst           = 1'b0;
      tw.load       = 1'b0;
      tw.en         = 1'b0;
      cs            = '{0, 0};
      ce            = '{0, 0};
      sel           = '{0, 0};
      apply_cfg(0, 0, 0);
      repeat (3) tick();
      chk("reset", outv(), 64'(0));
      rst   = 1'b1;
      tw.en = 1'b1;
      repeat (10) tick();
      chk("en_no_start", outv(), 64'(0));

      for (int i = 0; i < 19; i++) begin
         apply_cfg(vt[i].pi, vt[i].pt, vt[i].ps);
         do_load(1'b1);
         tw.en = 1'b1;
         repeat (vt[i].cyc) tick();
         chk($sformatf("vec%0d", i), outv(),
             pack(vt[i].crank, 2'b00, vt[i].idx, vt[i].ph,
                  vt[i].per, vt[i].rev, 1'b1));
      end

      apply_cfg(128, 100, 1);
      do_load(1'b1);
      tw.en = 1'b1;
      wait_idx(30, 4000, "t30");
      chk("accel_t30", 64'(tw.per_cur), 64'(100));
      tw.per_target = 16'd110;
      tw.per_step   = 16'd4;
      wait_idx(31, 300, "t31");
      chk("accel_t31", 64'(tw.per_cur), 64'(104));
      wait_idx(32, 300, "t32");
      chk("accel_t32", 64'(tw.per_cur), 64'(108));
      wait_idx(33, 300, "t33");
      chk("accel_t33", 64'(tw.per_cur), 64'(110));
      wait_idx(34, 300, "t34");
      chk("accel_t34", 64'(tw.per_cur), 64'(110));

      apply_cfg(64, 64, 0);
      do_load(1'b1);
      tw.en = 1'b1;
      repeat (660) tick();
      tw.en = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick();
         chk($sformatf("freeze_%0d", i), outv(),
             pack(1'b0, 2'b00, 10, 1'b0, 64, 1'b0, 1'b1));
         if (!last_ok) break;
      end
      tw.en = 1'b1;
      repeat (43) tick();
      chk("freeze_t10_end", 64'(tw.tooth_idx), 64'(10));
      tick();
      chk("freeze_t11", outv(),
          pack(1'b0, 2'b00, 11, 1'b0, 64, 1'b0, 1'b1));

      repeat (30 * 64 + 40 - 704) tick();
      chk("pre_rst", outv(),
          pack(1'b1, 2'b00, 30, 1'b0, 64, 1'b0, 1'b1));
      #2 rst = 1'b0;
      #1 chk("async_rst", outv(), 64'(0));
      repeat (2) tick();
      rst   = 1'b1;
      tw.en = 1'b1;
      repeat (20) tick();
      chk("en_alone", outv(), 64'(0));

      apply_cfg(2, 2, 0);
      do_load(1'b1);
      tw.en = 1'b1;
      repeat (201) tick();
      chk("pre_load_t40", outv(),
          pack(1'b1, 2'b00, 40, 1'b1, 2, 1'b0, 1'b1));
      tw.per_init = 16'd6;
      tw.load     = 1'b1;
      tick();
      tw.load = 1'b0;
      chk("load_on_boundary", outv(),
          pack(1'b0, 2'b00, 0, 1'b0, 6, 1'b1, 1'b1));

      cs  = '{4, 50};
      ce  = '{54, 10};
      sel = '{1, 0};
      run_check("cam_win", 2, 2, 0, 260, 100, 1'b1);
      cs[0]  = 7;
      ce[0]  = 7;
      sel[0] = 1'b0;
      run_check("cam_eq", 2, 2, 0, 130, 100, 1'b1);

      cs = '{0, 0};
      ce = '{0, 0};
      run_check("big_up", 3, 20, 65535, 300, 100, 1'b1);
      run_check("big_dn", 30, 0, 60000, 300, 100, 1'b1);

      for (int r = 0; r < 5; r++) begin
         for (int c = 0; c < 2; c++) begin
            cs[c]  = $urandom_range(N - 1);
            ce[c]  = $urandom_range(N - 1);
            sel[c] = 1'($urandom_range(1));
         end
         run_check($sformatf("rnd%0d", r),
                   $urandom_range(12), $urandom_range(12),
                   $urandom_range(3), 1500, 85,
                   1'($urandom_range(1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
